store_buffer: RTL and testbench
===============================

# store_buffer

Holds store instructions between dispatch and memory write. Entries are allocated in program order at dispatch and filled with address and data by the load/store unit. The ROB's store pop (`rob_sb_valid_o`) marks an entry committed, and committed entries then drain to data memory through a valid/ready handshake. A ROB mispredict flushes every uncommitted entry; committed entries survive and keep draining.

## Interface
- `SB_ENTRY`, 8: entry count; must be a power of 2 and ≥ 2.
- `ADDR_WIDTH`, 16: store address width.
- `DATA_WIDTH`, 16: store data width.

Ports:
- `clk_i` in 1: the block's single clock.
- `reset_n_i` in 1: reset, asynchronous and active-low.
- `alloc_valid_i` in 1: dispatch requests a store entry.
- `alloc_ready_o` out 1: an entry is free and no flush is in progress.
- `alloc_idx_o` out `$clog2(SB_ENTRY)`: index granted to the allocation, equal to the tail pointer.
- `lsu_wr_valid_i` in 1: the LSU supplies address and data.
- `lsu_wr_idx_i` in `$clog2(SB_ENTRY)`: entry being filled.
- `lsu_wr_addr_i` in `ADDR_WIDTH`: store address.
- `lsu_wr_data_i` in `DATA_WIDTH`: store data.
- `rob_sb_valid_i` in 1: ROB commits the oldest uncommitted store.
- `rob_mispredict_i` in 1: flush all uncommitted entries.
- `mem_valid_o` out 1: the head entry is committed and offered to memory.
- `mem_addr_o` out `ADDR_WIDTH`: head entry address.
- `mem_data_o` out `DATA_WIDTH`: head entry data.
- `mem_ready_i` in 1: memory accepts the write.
- `ld_addr_i` in `ADDR_WIDTH`: load address to forward from.
- `ld_hit_o` out 1: a matching store was found.
- `ld_data_o` out `DATA_WIDTH`: data from the youngest matching store.
- `sb_empty_o` out 1: no entry is in use.
- `sb_err_o` out 1: sticky protocol error.

## Operation
- Per-entry state is FREE → ALLOC → FILLED → COMMITTED → FREE.
- There are three pointers, plus a count of width `$clog2(SB_ENTRY)+1`:
  - `head`: the drain pointer.
  - `cmt`: the oldest uncommitted entry.
  - `tail`: the next entry to allocate.
- All pointers wrap modulo `SB_ENTRY`.
- **Allocate:** when `alloc_valid_i & alloc_ready_o`, the tail entry becomes ALLOC, `tail` increments and `count` increments.
- `alloc_ready_o` = (`count` < `SB_ENTRY`) & ~`rob_mispredict_i`. It uses the registered `count`, so a drain in the same cycle does not free a slot for that cycle.
- **Fill:** `lsu_wr_valid_i` on an entry in ALLOC latches address and data and moves the entry to FILLED. A fill on any other state leaves the entry unchanged and sets `sb_err_o`.
- **Commit:** `rob_sb_valid_i` requires the `cmt` entry to be FILLED; that entry becomes COMMITTED and `cmt` increments. If the entry is not FILLED, `sb_err_o` is set and nothing else changes.
- **Drain:** `mem_valid_o` = (head entry is COMMITTED). On `mem_valid_o & mem_ready_i` the entry becomes FREE, `head` increments and `count` decrements.
- `mem_addr_o`/`mem_data_o` are driven from entry registers and stay stable while `mem_valid_o` is high and the write is not yet accepted.
- **Flush:** `rob_mispredict_i` frees every ALLOC/FILLED entry and sets `tail` ← `cmt` and `count` ← (committed entries still held).
  - Allocation, fill and commit requests in the flush cycle are ignored.
  - A drain handshake in the flush cycle still completes and is included in the new `count`.
- **Simultaneous events in a non-flush cycle:** allocate, fill, commit and drain all take effect, each on its own entry.
- `sb_empty_o` = (`count` == 0).
- `sb_err_o` stays set until reset.

## Timing
- Allocation, fill, commit, drain and flush all update state on the rising `clk_i` edge.
- Committed-to-memory latency: `mem_valid_o` rises the cycle after the commit edge.
- Commit-and-drain bypass does not exist; minimum store lifetime is 3 cycles (allocate, fill, commit, then drain).
- Forwarding is combinational from `ld_addr_i` to `ld_hit_o`/`ld_data_o`, searching only registered state. Same-cycle fills are not forwarded.
- On `reset_n_i` low, asynchronously:
  - all entries FREE;
  - pointers and `count` 0;
  - `alloc_ready_o` = 1, `alloc_idx_o` = 0, `sb_empty_o` = 1;
  - `mem_valid_o`, `mem_addr_o`, `mem_data_o` = 0;
  - `ld_hit_o` = 0, `ld_data_o` = 0, `sb_err_o` = 0.
- Reset in the middle of a drain drops the store silently; memory must tolerate `mem_valid_o` falling without a handshake during reset.

## Configuration
- `SB_FWD_EN` defined: store-to-load forwarding is compiled in.
  - Entries in FILLED or COMMITTED state are searched from `tail`-1 back to `head`.
  - The youngest entry whose address equals `ld_addr_i` drives `ld_data_o` and sets `ld_hit_o` = 1.
  - With no match, `ld_hit_o` = 0 and `ld_data_o` = 0.
- `SB_FWD_EN` undefined: no search logic is built. The ports remain, with `ld_hit_o` and `ld_data_o` tied to 0.

## Test plan
- Allocate idx 0 → fill addr 0x0040 data 0xBEEF → `rob_sb_valid_i` pulse → next cycle `mem_valid_o`=1, `mem_addr_o`=0x0040, `mem_data_o`=0xBEEF; hold `mem_ready_i`=0 for 3 cycles so outputs stay stable; `mem_ready_i`=1 → `sb_empty_o`=1 next cycle.
- 8 allocations → `alloc_ready_o`=0 with `count`=8; drain one committed entry → `alloc_ready_o`=1 one cycle after the handshake; a 9th allocation receives `alloc_idx_o`=0 (pointer wrap).
- 2 committed and 3 filled entries, then `rob_mispredict_i` together with a drain handshake and an `alloc_valid_i` → `count`=1, `tail`=`cmt`, allocation ignored, the remaining committed store drains.
- `SB_FWD_EN`: stores to 0x0010 with data 0x1111 then 0x2222, both filled → `ld_addr_i`=0x0010 gives `ld_hit_o`=1, `ld_data_o`=0x2222; `ld_addr_i`=0x0012 gives `ld_hit_o`=0. Without the macro, `ld_hit_o`=0 in both cases.
- `rob_sb_valid_i` while the `cmt` entry is only ALLOC → `sb_err_o`=1 and stays set; no entry is committed.
- Assert `reset_n_i` low between clock edges while `mem_valid_o`=1 → all outputs reach their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : store_buffer
//  Purpose  : In-order store buffer between dispatch and data memory, with
//             commit tracking, mispredict flush and a valid/ready drain port.
//             Define SB_FWD_EN to build store-to-load forwarding.
//  Revision : 1.0  initial release
// ============================================================================
module store_buffer #(
    parameter int SB_ENTRY   = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        alloc_valid_i,
    output logic                        alloc_ready_o,
    output logic [$clog2(SB_ENTRY)-1:0] alloc_idx_o,
    input  logic                        lsu_wr_valid_i,
    input  logic [$clog2(SB_ENTRY)-1:0] lsu_wr_idx_i,
    input  logic [ADDR_WIDTH-1:0]       lsu_wr_addr_i,
    input  logic [DATA_WIDTH-1:0]       lsu_wr_data_i,
    input  logic                        rob_sb_valid_i,
    input  logic                        rob_mispredict_i,
    output logic                        mem_valid_o,
    output logic [ADDR_WIDTH-1:0]       mem_addr_o,
    output logic [DATA_WIDTH-1:0]       mem_data_o,
    input  logic                        mem_ready_i,
    input  logic [ADDR_WIDTH-1:0]       ld_addr_i,
    output logic                        ld_hit_o,
    output logic [DATA_WIDTH-1:0]       ld_data_o,
    output logic                        sb_empty_o,
    output logic                        sb_err_o
);

    localparam int IDX_W = $clog2(SB_ENTRY);
    localparam logic [IDX_W:0]   c_FULL_COUNT = (IDX_W+1)'(SB_ENTRY);
    localparam logic [IDX_W:0]   c_COUNT_ONE  = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] c_PTR_ONE    = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_FREE      = 2'd0,
        ST_ALLOC     = 2'd1,
        ST_FILLED    = 2'd2,
        ST_COMMITTED = 2'd3
    } entry_state_t;

    entry_state_t          r_state     [SB_ENTRY];
    entry_state_t          w_state_nxt [SB_ENTRY];
    logic [ADDR_WIDTH-1:0] r_addr      [SB_ENTRY];
    logic [DATA_WIDTH-1:0] r_data      [SB_ENTRY];

    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_cmt;
    logic [IDX_W-1:0] r_tail;
    logic [IDX_W:0]   r_count;
    logic             r_err;

    logic           w_flush;
    logic           w_alloc_ready;
    logic           w_alloc_fire;
    logic           w_fill_req;
    logic           w_fill_ok;
    logic           w_fill_err;
    logic           w_cmt_req;
    logic           w_cmt_ok;
    logic           w_cmt_err;
    logic           w_mem_valid;
    logic           w_drain;
    logic [IDX_W:0] w_cmt_held;

    assign w_flush       = rob_mispredict_i;
    // Registered count only: a same-cycle drain does not open a slot.
    assign w_alloc_ready = (r_count < c_FULL_COUNT) & ~w_flush;
    assign w_alloc_fire  = alloc_valid_i & w_alloc_ready;

    assign w_fill_req = lsu_wr_valid_i & ~w_flush;
    assign w_fill_ok  = w_fill_req & (r_state[lsu_wr_idx_i] == ST_ALLOC);
    assign w_fill_err = w_fill_req & (r_state[lsu_wr_idx_i] != ST_ALLOC);

    assign w_cmt_req = rob_sb_valid_i & ~w_flush;
    assign w_cmt_ok  = w_cmt_req & (r_state[r_cmt] == ST_FILLED);
    assign w_cmt_err = w_cmt_req & (r_state[r_cmt] != ST_FILLED);

    assign w_mem_valid = (r_state[r_head] == ST_COMMITTED);
    assign w_drain     = w_mem_valid & mem_ready_i;

    // Committed entries survive a flush and define the post-flush occupancy.
    always_comb begin
        w_cmt_held = '0;
        for (int i = 0; i < SB_ENTRY; i++) begin
            if (r_state[i] == ST_COMMITTED) begin
                w_cmt_held = w_cmt_held + c_COUNT_ONE;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < SB_ENTRY; i++) begin
            w_state_nxt[i] = r_state[i];
            if (w_flush) begin
                if (r_state[i] == ST_ALLOC || r_state[i] == ST_FILLED) begin
                    w_state_nxt[i] = ST_FREE;
                end else if (w_drain && r_head == IDX_W'(i)) begin
                    w_state_nxt[i] = ST_FREE;
                end
            end else begin
                if (w_alloc_fire && r_tail == IDX_W'(i)) begin
                    w_state_nxt[i] = ST_ALLOC;
                end
                if (w_fill_ok && lsu_wr_idx_i == IDX_W'(i)) begin
                    w_state_nxt[i] = ST_FILLED;
                end
                if (w_cmt_ok && r_cmt == IDX_W'(i)) begin
                    w_state_nxt[i] = ST_COMMITTED;
                end
                if (w_drain && r_head == IDX_W'(i)) begin
                    w_state_nxt[i] = ST_FREE;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < SB_ENTRY; i++) begin
                r_state[i] <= ST_FREE;
                r_addr[i]  <= '0;
                r_data[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < SB_ENTRY; i++) begin
                r_state[i] <= w_state_nxt[i];
            end
            if (w_fill_ok) begin
                r_addr[lsu_wr_idx_i] <= lsu_wr_addr_i;
                r_data[lsu_wr_idx_i] <= lsu_wr_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_head  <= '0;
            r_cmt   <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_drain) begin
                r_head <= r_head + c_PTR_ONE;
            end
            if (w_flush) begin
                r_tail  <= r_cmt;
                r_count <= w_drain ? (w_cmt_held - c_COUNT_ONE) : w_cmt_held;
            end else begin
                if (w_alloc_fire) begin
                    r_tail <= r_tail + c_PTR_ONE;
                end
                if (w_cmt_ok) begin
                    r_cmt <= r_cmt + c_PTR_ONE;
                end
                case ({w_alloc_fire, w_drain})
                    2'b10:   r_count <= r_count + c_COUNT_ONE;
                    2'b01:   r_count <= r_count - c_COUNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
            if (w_fill_err || w_cmt_err) begin
                r_err <= 1'b1;
            end
        end
    end

    logic                  w_ld_hit;
    logic [DATA_WIDTH-1:0] w_ld_data;

`ifdef SB_FWD_EN
    logic [IDX_W-1:0] w_fwd_idx;

    // Walk oldest to youngest so the youngest match is the last one written.
    always_comb begin
        w_ld_hit  = 1'b0;
        w_ld_data = '0;
        w_fwd_idx = '0;
        for (int k = 0; k < SB_ENTRY; k++) begin
            w_fwd_idx = r_head + IDX_W'(k);
            if ((r_state[w_fwd_idx] == ST_FILLED || r_state[w_fwd_idx] == ST_COMMITTED) &&
                r_addr[w_fwd_idx] == ld_addr_i) begin
                w_ld_hit  = 1'b1;
                w_ld_data = r_data[w_fwd_idx];
            end
        end
    end
`else
    logic w_unused_ld_addr;

    assign w_unused_ld_addr = ^ld_addr_i;
    assign w_ld_hit         = 1'b0;
    assign w_ld_data        = '0;
`endif

    assign alloc_ready_o = w_alloc_ready;
    assign alloc_idx_o   = r_tail;
    assign mem_valid_o   = w_mem_valid;
    assign mem_addr_o    = r_addr[r_head];
    assign mem_data_o    = r_data[r_head];
    assign ld_hit_o      = w_ld_hit;
    assign ld_data_o     = w_ld_data;
    assign sb_empty_o    = (r_count == '0);
    assign sb_err_o      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_store_buffer
//  Purpose  : Directed vector bench for store_buffer (drain, full/wrap,
//             flush, error, forwarding and asynchronous reset).
//  Revision : 1.0  initial release
// ============================================================================
module tb_store_buffer;

`ifdef SB_FWD_EN
    localparam bit c_FWD = 1'b1;
`else
    localparam bit c_FWD = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [2:0]  alloc_idx;
    logic        lsu_wr_valid;
    logic [2:0]  lsu_wr_idx;
    logic [15:0] lsu_wr_addr;
    logic [15:0] lsu_wr_data;
    logic        rob_sb_valid;
    logic        rob_mispredict;
    logic        mem_valid;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic [15:0] ld_addr;
    logic        ld_hit;
    logic [15:0] ld_data;
    logic        sb_empty;
    logic        sb_err;

    int checks = 0;
    int errors = 0;

    store_buffer #(.SB_ENTRY(8), .ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .alloc_valid_i   (alloc_valid),
        .alloc_ready_o   (alloc_ready),
        .alloc_idx_o     (alloc_idx),
        .lsu_wr_valid_i  (lsu_wr_valid),
        .lsu_wr_idx_i    (lsu_wr_idx),
        .lsu_wr_addr_i   (lsu_wr_addr),
        .lsu_wr_data_i   (lsu_wr_data),
        .rob_sb_valid_i  (rob_sb_valid),
        .rob_mispredict_i(rob_mispredict),
        .mem_valid_o     (mem_valid),
        .mem_addr_o      (mem_addr),
        .mem_data_o      (mem_data),
        .mem_ready_i     (mem_ready),
        .ld_addr_i       (ld_addr),
        .ld_hit_o        (ld_hit),
        .ld_data_o       (ld_data),
        .sb_empty_o      (sb_empty),
        .sb_err_o        (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          alloc;
        bit          wr;
        logic [2:0]  widx;
        logic [15:0] waddr;
        logic [15:0] wdata;
        bit          rob;
        bit          misp;
        bit          mrdy;
        logic [15:0] ld;
        logic [55:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Expected record: {alloc_ready, alloc_idx, mem_valid, mem_addr, mem_data,
    // sb_empty, sb_err, ld_hit, ld_data}; forwarding fields zeroed without SB_FWD_EN.
    function automatic vec_t mk(bit rst, bit alloc, bit wr, logic [2:0] widx,
                                logic [15:0] waddr, logic [15:0] wdata,
                                bit rob, bit misp, bit mrdy, logic [15:0] ld,
                                bit e_rdy, logic [2:0] e_idx, bit e_mv,
                                logic [15:0] e_ma, logic [15:0] e_md,
                                bit e_emp, bit e_err, bit e_hit, logic [15:0] e_ld);
        vec_t v;
        v.rst = rst; v.alloc = alloc; v.wr = wr; v.widx = widx;
        v.waddr = waddr; v.wdata = wdata; v.rob = rob; v.misp = misp;
        v.mrdy = mrdy; v.ld = ld;
        if (!c_FWD) begin
            e_hit = 1'b0;
            e_ld  = 16'h0000;
        end
        v.exp = {e_rdy, e_idx, e_mv, e_ma, e_md, e_emp, e_err, e_hit, e_ld};
        return v;
    endfunction

    function automatic logic [55:0] actual();
        return {alloc_ready, alloc_idx, mem_valid, mem_addr, mem_data,
                sb_empty, sb_err, ld_hit, ld_data};
    endfunction

    task automatic check(input string name, input logic [55:0] act, input logic [55:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_ctrl();
        alloc_valid    = 1'b0;
        lsu_wr_valid   = 1'b0;
        rob_sb_valid   = 1'b0;
        rob_mispredict = 1'b0;
        mem_ready      = 1'b0;
    endtask

    localparam logic [55:0] c_RST_EXP = {1'b1, 3'd0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0};

    task automatic do_reset(input string name);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check(name, actual(), c_RST_EXP);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        clear_ctrl();
        lsu_wr_idx  = '0;
        lsu_wr_addr = '0;
        lsu_wr_data = '0;
        ld_addr     = '0;

        // Single store: fill, commit, held drain, accept
        tbl.push_back(mk(1,1,0,0,16'h0,16'h0,   0,0,0,16'h0040, 1,1,0,16'h0000,16'h0000,0,0,0,16'h0000));
        tbl.push_back(mk(0,0,1,0,16'h0040,16'hBEEF,0,0,0,16'h0040, 1,1,0,16'h0040,16'hBEEF,0,0,1,16'hBEEF));
        tbl.push_back(mk(0,0,0,0,16'h0,16'h0,   1,0,0,16'h0040, 1,1,1,16'h0040,16'hBEEF,0,0,1,16'hBEEF));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0,0,0,0,16'h0,16'h0,0,0,0,16'h0040, 1,1,1,16'h0040,16'hBEEF,0,0,1,16'hBEEF));
        tbl.push_back(mk(0,0,0,0,16'h0,16'h0,   0,0,1,16'h0040, 1,1,0,16'h0000,16'h0000,1,0,0,16'h0000));

        // Fill to capacity, drain one, wrap the tail
        for (int k = 1; k <= 8; k++)
            tbl.push_back(mk(k == 1,1,0,0,16'h0,16'h0,0,0,0,16'h0,
                             k < 8, 3'(k % 8), 0,16'h0,16'h0,0,0,0,16'h0));
        tbl.push_back(mk(0,0,1,0,16'h0100,16'h0001,0,0,0,16'h0, 0,0,0,16'h0100,16'h0001,0,0,0,16'h0));
        tbl.push_back(mk(0,0,0,0,16'h0,16'h0,   1,0,0,16'h0, 0,0,1,16'h0100,16'h0001,0,0,0,16'h0));
        tbl.push_back(mk(0,1,0,0,16'h0,16'h0,   0,0,0,16'h0, 0,0,1,16'h0100,16'h0001,0,0,0,16'h0));
        tbl.push_back(mk(0,0,0,0,16'h0,16'h0,   0,0,1,16'h0, 1,0,0,16'h0000,16'h0000,0,0,0,16'h0));
        tbl.push_back(mk(0,1,0,0,16'h0,16'h0,   0,0,0,16'h0, 0,1,0,16'h0000,16'h0000,0,0,0,16'h0));

        // 2 committed + 3 filled, then flush with drain, alloc, fill and commit
        tbl.push_back(mk(1,1,0,0,16'h0,16'h0,   0,0,0,16'h0202, 1,1,0,16'h0000,16'h0000,0,0,0,16'h0));
        tbl.push_back(mk(0,1,1,0,16'h0200,16'hA000,0,0,0,16'h0202, 1,2,0,16'h0200,16'hA000,0,0,0,16'h0));
        tbl.push_back(mk(0,1,1,1,16'h0201,16'hA001,1,0,0,16'h0202, 1,3,1,16'h0200,16'hA000,0,0,0,16'h0));
        tbl.push_back(mk(0,1,1,2,16'h0202,16'hA002,1,0,0,16'h0202, 1,4,1,16'h0200,16'hA000,0,0,1,16'hA002));
        tbl.push_back(mk(0,1,1,3,16'h0203,16'hA003,0,0,0,16'h0202, 1,5,1,16'h0200,16'hA000,0,0,1,16'hA002));
        tbl.push_back(mk(0,0,1,4,16'h0204,16'hA004,0,0,0,16'h0202, 1,5,1,16'h0200,16'hA000,0,0,1,16'hA002));
        tbl.push_back(mk(0,1,1,5,16'h0205,16'hA005,1,1,1,16'h0202, 1,2,1,16'h0201,16'hA001,0,0,0,16'h0));
        tbl.push_back(mk(0,0,0,0,16'h0,16'h0,   0,0,1,16'h0202, 1,2,0,16'h0202,16'hA002,1,0,0,16'h0));
        tbl.push_back(mk(0,1,0,0,16'h0,16'h0,   0,0,0,16'h0202, 1,3,0,16'h0202,16'hA002,0,0,0,16'h0));

        // Commit of an unfilled entry: sticky error, nothing committed
        tbl.push_back(mk(1,1,0,0,16'h0,16'h0,   0,0,0,16'h0030, 1,1,0,16'h0000,16'h0000,0,0,0,16'h0));
        tbl.push_back(mk(0,0,0,0,16'h0,16'h0,   1,0,0,16'h0030, 1,1,0,16'h0000,16'h0000,0,1,0,16'h0));
        tbl.push_back(mk(0,0,0,0,16'h0,16'h0,   0,0,0,16'h0030, 1,1,0,16'h0000,16'h0000,0,1,0,16'h0));
        tbl.push_back(mk(0,0,1,0,16'h0030,16'h3333,0,0,0,16'h0030, 1,1,0,16'h0030,16'h3333,0,1,1,16'h3333));
        tbl.push_back(mk(0,0,0,0,16'h0,16'h0,   1,0,0,16'h0030, 1,1,1,16'h0030,16'h3333,0,1,1,16'h3333));

        // Forwarding: youngest of two same-address stores wins
        tbl.push_back(mk(1,1,0,0,16'h0,16'h0,   0,0,0,16'h0010, 1,1,0,16'h0000,16'h0000,0,0,0,16'h0));
        tbl.push_back(mk(0,1,1,0,16'h0010,16'h1111,0,0,0,16'h0010, 1,2,0,16'h0010,16'h1111,0,0,1,16'h1111));
        tbl.push_back(mk(0,0,1,1,16'h0010,16'h2222,0,0,0,16'h0010, 1,2,0,16'h0010,16'h1111,0,0,1,16'h2222));
        tbl.push_back(mk(0,0,0,0,16'h0,16'h0,   0,0,0,16'h0012, 1,2,0,16'h0010,16'h1111,0,0,0,16'h0));
        tbl.push_back(mk(0,0,0,0,16'h0,16'h0,   1,0,0,16'h0010, 1,2,1,16'h0010,16'h1111,0,0,1,16'h2222));

        for (int n = 0; n < tbl.size(); n++) begin
            if (tbl[n].rst) do_reset($sformatf("reset_before_vec%0d", n));
            @(negedge clk);
            alloc_valid    = tbl[n].alloc;
            lsu_wr_valid   = tbl[n].wr;
            lsu_wr_idx     = tbl[n].widx;
            lsu_wr_addr    = tbl[n].waddr;
            lsu_wr_data    = tbl[n].wdata;
            rob_sb_valid   = tbl[n].rob;
            rob_mispredict = tbl[n].misp;
            mem_ready      = tbl[n].mrdy;
            ld_addr        = tbl[n].ld;
            @(posedge clk);
            #1;
            clear_ctrl();
            #1;
            check($sformatf("vec%0d", n), actual(), tbl[n].exp);
        end

        // Asynchronous reset mid-drain, between clock edges
        @(negedge clk);
        #2;
        check("async_pre_mem_valid", {55'd0, mem_valid}, 56'd1);
        reset_n = 1'b0;
        #1;
        check("async_reset_immediate", actual(), c_RST_EXP);
        @(negedge clk);
        check("async_reset_held", actual(), c_RST_EXP);
        reset_n = 1'b1;
        @(negedge clk);
        check("after_reset_release", actual(), c_RST_EXP);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
